// File: rtl/de0_nano_boot_copier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : de0_nano_boot_copier_pkg
//  Description : Shared types and constants for the boot copier: FSM state
//                encoding, fixed Wishbone cycle-type/burst/select values and
//                a word-alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package de0_nano_boot_copier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [1:0]  BTE_LINEAR  = 2'b00;
    localparam logic [3:0]  SEL_WORD    = 4'hF;
    localparam logic [31:0] WORD_STEP   = 32'd4;

    // Byte address -> word address; the low two bits are never used.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/de0_nano_boot_copier_if.sv
`default_nettype none
// ============================================================================
//  Module      : de0_nano_boot_copier_if
//  Description : Wishbone classic single-access bus bundle.
//                master : adr, dat_w, sel, we, cyc, stb, cti, bte out;
//                         dat_r, ack, err in.
//                slave  : the mirror image.
//  Revision    : 1.0 - initial release
// ============================================================================
interface de0_nano_boot_copier_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err
    );
endinterface
`default_nettype wire

// File: rtl/de0_nano_boot_copier_wb_access_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : wb_access_timeout
//  Description : Per-access watchdog. Counts cycles with stb high and no ack;
//                o_expired is high during the TIMEOUT-th such cycle so the
//                master can abort on that edge. TIMEOUT=0 disables it.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_stb, i_ack    - strobe / acknowledge of the watched access
//                o_expired       - access has waited TIMEOUT cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_access_timeout #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_stb,
    input  wire logic i_ack,
    output logic      o_expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign o_expired = 1'b0;
        end else begin : g_enabled
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || !i_stb || i_ack) begin
                    r_count <= '0;
                end else if (r_count != c_last) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_expired = i_stb && !i_ack && (r_count == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/de0_nano_boot_copier.sv
`default_nettype none
// ============================================================================
//  Module      : de0_nano_boot_copier
//  Description : Wishbone classic master copying len_i 32-bit words from
//                src_i to dst_i, one read then one write per word, with a
//                one-cycle cyc/stb gap after every access for re-arbitration.
//  Ports       : wb_clk_i, wb_rst_i       - clock, sync active-high reset
//                start_i, src_i, dst_i,
//                len_i                    - copy request (taken in IDLE only)
//                busy_o, done_o, err_o    - status
//                wbm                      - Wishbone master bus
//  Revision    : 1.0 - initial release
// ============================================================================
module de0_nano_boot_copier
    import de0_nano_boot_copier_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic             wb_clk_i,
    input  wire logic             wb_rst_i,
    input  wire logic             start_i,
    input  wire logic [31:0]      src_i,
    input  wire logic [31:0]      dst_i,
    input  wire logic [LEN_W-1:0] len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    de0_nano_boot_copier_if.master wbm
);

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    state_t           r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_adr;
    logic [31:0]      r_data;
    logic             r_we;
    logic             r_cyc;
    logic             r_stb;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_timeout;
    logic             w_abort;

    wb_access_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_stb     (r_stb),
        .i_ack     (wbm.ack),
        .o_expired (w_timeout)
    );

    // Only meaningful while r_stb is high; err takes priority over ack.
    assign w_abort = wbm.err || w_timeout;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_src  <= word_align(src_i);
                        r_dst  <= word_align(dst_i);
                        r_cnt  <= len_i;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= ST_FINISH;
                        end else begin
                            // First read goes out immediately; there is no
                            // preceding access to leave a gap after.
                            r_state <= ST_READ;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_adr   <= word_align(src_i);
                        end
                    end
                end
                ST_READ: begin
                    if (!r_stb) begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_we  <= 1'b0;
                        r_adr <= r_src;
                    end else if (w_abort) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= ST_FINISH;
                    end else if (wbm.ack) begin
                        r_data  <= wbm.dat_r;
                        r_src   <= r_src + WORD_STEP;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!r_stb) begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_we  <= 1'b1;
                        r_adr <= r_dst;
                    end else if (w_abort) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_FINISH;
                    end else if (wbm.ack) begin
                        r_dst   <= r_dst + WORD_STEP;
                        r_cnt   <= r_cnt - c_one;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= (r_cnt == c_one) ? ST_FINISH : ST_READ;
                    end
                end
                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign wbm.adr   = r_adr;
    assign wbm.dat_w = r_data;
    assign wbm.sel   = SEL_WORD;
    assign wbm.we    = r_we;
    assign wbm.cyc   = r_cyc;
    assign wbm.stb   = r_stb;
    assign wbm.cti   = CTI_CLASSIC;
    assign wbm.bte   = BTE_LINEAR;

endmodule
`default_nettype wire

// File: tb/tb_de0_nano_boot_copier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_de0_nano_boot_copier
//  Description : Self-checking bench for de0_nano_boot_copier. A table of copy
//                requests drives a configurable wait/err slave; expected bus
//                reads and writes are queued when a request is issued and
//                popped as the slave completes accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_de0_nano_boot_copier;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;

    de0_nano_boot_copier_if bus ();

    de0_nano_boot_copier #(
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start_i  (start),
        .src_i    (src),
        .dst_i    (dst),
        .len_i    (len),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .wbm      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source memory contents seen by the slave.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a[31:4] == 28'hF000000) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        return a ^ 32'hDEADBEEF;
    endfunction

    // ---------------- slave model ----------------
    int   s_wait  = 0;   // wait states per access
    int   s_errw  = 0;   // 1-based write index answered with err (0: none)
    bit   s_stray = 1'b0;// drive ack while stb is low
    int   wcnt    = 0;
    int   wr_seen = 0;
    logic resp;

    always_comb begin
        resp      = bus.cyc && bus.stb && (wcnt == s_wait);
        // err on the chosen write also raises ack, so err must win.
        bus.ack   = resp || (s_stray && !bus.stb);
        bus.err   = resp && bus.we && (s_errw != 0) && (wr_seen + 1 == s_errw);
        bus.dat_r = bus.stb ? mem_val(bus.adr) : 32'h0BAD0BAD;
    end

    always @(posedge clk) begin
        if (bus.cyc && bus.stb && !resp) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
        if (!busy)                 wr_seen <= 0;
        else if (resp && bus.we)   wr_seen <= wr_seen + 1;
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    int          stb_cycles  = 0;
    int          done_pulses = 0;
    bit          prev_wait   = 1'b0;
    logic [31:0] h_adr, h_dat;
    logic        h_we;

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (bus.stb) begin
            stb_cycles++;
            chk("bus_const", {bus.sel, bus.cti, bus.bte, bus.cyc}, {4'hF, 3'b000, 2'b00, 1'b1});
            if (prev_wait) begin
                chk("hold_adr", bus.adr, h_adr);
                chk("hold_we", bus.we, h_we);
                if (bus.we) chk("hold_dat", bus.dat_w, h_dat);
            end
            if (bus.ack || bus.err) begin
                prev_wait = 1'b0;
                if (!bus.err) begin
                    if (bus.we) begin
                        if (wr_q.size() == 0) begin
                            chk("unexpected_write", bus.adr, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            wr_t e;
                            e = wr_q.pop_front();
                            chk("wr_adr", bus.adr, e.adr);
                            chk("wr_dat", bus.dat_w, e.dat);
                        end
                    end else begin
                        if (rd_q.size() == 0) begin
                            chk("unexpected_read", bus.adr, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            logic [31:0] ea;
                            ea = rd_q.pop_front();
                            chk("rd_adr", bus.adr, ea);
                        end
                    end
                end
            end else begin
                prev_wait = 1'b1;
                h_adr = bus.adr;
                h_dat = bus.dat_w;
                h_we  = bus.we;
            end
        end else begin
            prev_wait = 1'b0;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          wt;       // slave wait states
        int          errw;     // write index answered with err
        bit          stray;    // stray ack outside stb
        int          restart;  // cycle after start to pulse a second start (0: none)
        int          n_rd;     // reads expected to complete
        int          n_wr;     // writes expected to complete
        int          done_dly; // edges after the start edge until done is seen
        bit          exp_err;
        int          stb_cyc;  // total cycles with stb high
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int d;
        int p0;
        for (int i = 0; i < v.n_rd; i++)
            rd_q.push_back((v.src & 32'hFFFF_FFFC) + 32'(4 * i));
        for (int i = 0; i < v.n_wr; i++) begin
            wr_t e;
            e.adr = (v.dst & 32'hFFFF_FFFC) + 32'(4 * i);
            e.dat = mem_val((v.src & 32'hFFFF_FFFC) + 32'(4 * i));
            wr_q.push_back(e);
        end
        s_wait = v.wt; s_errw = v.errw; s_stray = v.stray;
        stb_cycles = 0;
        p0 = done_pulses;
        @(negedge clk);
        src = v.src; dst = v.dst; len = LEN_W'(v.len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("err_clear", err, 0);
        d = 0;
        while (!done && d < 200) begin
            @(negedge clk);
            d++;
            start = (v.restart != 0) && (d == v.restart);
            if (start) begin
                src = 32'h0000_9000; dst = 32'h0000_A000; len = LEN_W'(5);
            end
        end
        start = 1'b0;
        chk("done_dly", d, v.done_dly);
        chk("err_o", err, v.exp_err);
        chk("busy_fall", busy, 0);
        @(negedge clk);
        chk("done_width", done, 0);
        repeat (4) @(negedge clk);
        chk("done_count", done_pulses - p0, 1);
        chk("stb_cycles", stb_cycles, v.stb_cyc);
        chk("rd_left", rd_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        rd_q.delete(); wr_q.delete();
        s_stray = 1'b0; s_errw = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int p0;
        //               src            dst            len wt errw str rs rd wr dly er stb
        vecs[0] = '{32'hF000_0000, 32'h0010_0000, 4, 0,   0, 0, 0, 4, 4, 16, 0,  8};
        vecs[1] = '{32'hF000_0000, 32'h0010_0000, 4, 3,   0, 0, 0, 4, 4, 40, 0, 32};
        vecs[2] = '{32'hF000_0000, 32'h0010_0000, 4, 2,   0, 0, 0, 4, 4, 32, 0, 24};
        vecs[3] = '{32'h0000_1000, 32'h0000_2000, 0, 0,   0, 0, 0, 0, 0,  1, 0,  0};
        vecs[4] = '{32'h0000_2000, 32'h0000_3000, 3, 0,   2, 1, 0, 2, 1,  8, 1,  4};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_4000, 2, 0,   0, 0, 0, 2, 2,  8, 0,  4};
        vecs[6] = '{32'h0000_0103, 32'hFFFF_FFF8, 3, 1,   0, 1, 0, 3, 3, 18, 0, 12};
        vecs[7] = '{32'h0000_5000, 32'h0000_6000, 2, 100, 0, 0, 0, 0, 0,  9, 1,  8};
        vecs[8] = '{32'h0000_7000, 32'h0000_8000, 2, 0,   0, 0, 3, 2, 2,  8, 0,  4};
        vecs[9] = '{32'h0000_7100, 32'h0000_8100, 2, 0,   0, 0, 7, 2, 2,  8, 0,  4};

        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, err, bus.cyc, bus.stb, bus.we}, 0);
        chk("rst_adr", bus.adr, 0);
        chk("rst_dat", bus.dat_w, 0);
        chk("rst_const", {bus.sel, bus.cti, bus.bte}, {4'hF, 5'b0});
        rst = 1'b0;
        stb_cycles = 0;
        repeat (100) @(negedge clk);
        chk("idle_stb", stb_cycles, 0);
        chk("idle_status", {busy, done, err, bus.cyc}, 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset in the middle of a write: bus released next cycle, no done.
        s_wait = 3;
        rd_q.push_back(32'hF000_0000);
        p0 = done_pulses;
        @(negedge clk);
        src = 32'hF000_0000; dst = 32'h0010_0000; len = LEN_W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d = 0;
        while (!(bus.stb && bus.we) && d < 50) begin
            @(negedge clk);
            d++;
        end
        chk("mid_write_reached", bus.stb && bus.we, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_bus", {bus.cyc, bus.stb, bus.we}, 0);
        chk("rst_mid_status", {busy, done, err}, 0);
        chk("rst_mid_adr", bus.adr, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_done", done_pulses - p0, 0);
        chk("rst_rd_left", rd_q.size(), 0);
        chk("rst_idle_cyc", bus.cyc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
